// File: rtl/follower_pkg.sv
`default_nettype none
// ============================================================================
// Module : follower_pkg
// Desc   : Shared widths, state encoding and the servo clamp helper.
// Rev    : 1.0
// ============================================================================
package follower_pkg;

    localparam int SERVO_W  = 13;
    localparam int SENSOR_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FOLLOW = 2'd1,
        ST_SEARCH = 2'd2,
        ST_FINISH = 2'd3
    } follower_state_t;

    function automatic logic signed [SERVO_W-1:0] servo_clamp(
        input logic signed [SERVO_W-1:0] value,
        input logic signed [SERVO_W-1:0] lim
    );
        if (value > lim) begin
            return lim;
        end else if (value < -lim) begin
            return -lim;
        end
        return value;
    endfunction

endpackage
`default_nettype wire

// File: rtl/follower_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : follower_ctrl_if
// Desc   : Sensor/PID inputs and steering outputs of the mode sequencer.
// Rev    : 1.0
// ============================================================================
interface follower_ctrl_if;
    import follower_pkg::*;

    logic                       start;
    logic [SENSOR_W-1:0]        sensors;
    logic signed [SERVO_W-1:0]  pid_in;
    logic                       sample_tick;
    logic                       pid_clr;
    logic                       kp_sw;
    logic                       ki_sw;
    logic                       kd_sw;
    logic signed [SERVO_W-1:0]  servo_cmd;
    logic [1:0]                 follower_state;

    modport master (
        output start, sensors, pid_in,
        input  sample_tick, pid_clr, kp_sw, ki_sw, kd_sw, servo_cmd, follower_state
    );

    modport slave (
        input  start, sensors, pid_in,
        output sample_tick, pid_clr, kp_sw, ki_sw, kd_sw, servo_cmd, follower_state
    );
endinterface
`default_nettype wire

// File: rtl/ctrl_tick_gen.sv
`default_nettype none
// ============================================================================
// Module : ctrl_tick_gen
// Desc   : Free-running sample-tick divider; one-cycle registered strobe.
// Rev    : 1.0
// ============================================================================
module ctrl_tick_gen #(
    parameter int TICK_DIV = 100000
) (
    input  wire  clk,
    input  wire  rst,
    output logic sample_tick
);
    localparam int c_cnt_w = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(TICK_DIV - 1);

    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic               r_tick;

    always_comb begin
        w_cnt_nxt = (r_cnt == c_last) ? '0 : r_cnt + 1'b1;
    end

    // Strobe is a flop that is high exactly while the counter holds its last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_tick <= (w_cnt_nxt == c_last);
        end
    end

    assign sample_tick = r_tick;

endmodule
`default_nettype wire

// File: rtl/follower_ctrl.sv
`default_nettype none
// ============================================================================
// Module : follower_ctrl
// Desc   : Line-follower steering mode sequencer (IDLE/FOLLOW/SEARCH/FINISH).
//          Optional macro FOLLOWER_SEARCH_TIMEOUT_EN bounds time spent in SEARCH.
// Rev    : 1.0
// ============================================================================
module follower_ctrl
    import follower_pkg::*;
#(
    parameter int                        TICK_DIV     = 100000,
    parameter int                        LOST_TICKS   = 20,
    parameter int                        FINISH_TICKS = 10,
    parameter int                        STABLE_TICKS = 50,
    parameter logic signed [SERVO_W-1:0] SEARCH_MAG   = 13'sd600,
    parameter logic signed [SERVO_W-1:0] SERVO_LIM    = 13'sd1000
`ifdef FOLLOWER_SEARCH_TIMEOUT_EN
    ,
    parameter int                        SEARCH_TIMEOUT = 2000
`endif
) (
    input  wire            clk,
    input  wire            rst,
    follower_ctrl_if.slave bus
);
    localparam int c_lost_w   = $clog2(LOST_TICKS + 1);
    localparam int c_fin_w    = $clog2(FINISH_TICKS + 1);
    localparam int c_stable_w = $clog2(STABLE_TICKS + 1);
    localparam logic [c_lost_w-1:0]   c_lost_lim   = c_lost_w'(LOST_TICKS);
    localparam logic [c_fin_w-1:0]    c_fin_lim    = c_fin_w'(FINISH_TICKS);
    localparam logic [c_stable_w-1:0] c_stable_lim = c_stable_w'(STABLE_TICKS);

    follower_state_t           r_state, w_state_nxt;
    logic [c_lost_w-1:0]       r_lost_cnt, w_lost_nxt;
    logic [c_fin_w-1:0]        r_fin_cnt, w_fin_nxt;
    logic [c_stable_w-1:0]     r_stable_cnt, w_stable_nxt;
    logic                      r_last_dir, w_dir_nxt;
    logic                      r_start_q;
    logic                      w_start_rise;
    logic                      w_tick;
    logic signed [SERVO_W-1:0] r_servo, w_servo_nxt;
    logic                      r_pid_clr, w_pid_clr_nxt;
    logic                      r_kp, w_kp_nxt;
    logic                      r_ki, w_ki_nxt;
    logic                      r_kd, w_kd_nxt;
`ifdef FOLLOWER_SEARCH_TIMEOUT_EN
    localparam int c_search_w = $clog2(SEARCH_TIMEOUT + 1);
    localparam logic [c_search_w-1:0] c_search_lim = c_search_w'(SEARCH_TIMEOUT);
    logic [c_search_w-1:0]     r_search_cnt, w_search_nxt;
`endif

    ctrl_tick_gen #(
        .TICK_DIV    (TICK_DIV)
    ) u_tick_gen (
        .clk         (clk),
        .rst         (rst),
        .sample_tick (w_tick)
    );

    assign w_start_rise = bus.start & ~r_start_q;

    always_comb begin
        w_state_nxt  = r_state;
        w_lost_nxt   = r_lost_cnt;
        w_fin_nxt    = r_fin_cnt;
        w_stable_nxt = r_stable_cnt;
        w_dir_nxt    = r_last_dir;
`ifdef FOLLOWER_SEARCH_TIMEOUT_EN
        w_search_nxt = '0;
`endif
        case (r_state)
            ST_IDLE, ST_FINISH: begin
                if (w_start_rise) begin
                    w_state_nxt  = ST_FOLLOW;
                    w_lost_nxt   = '0;
                    w_fin_nxt    = '0;
                    w_stable_nxt = '0;
                end
            end
            ST_FOLLOW: begin
                if (w_tick) begin
                    if (r_stable_cnt < c_stable_lim) begin
                        w_stable_nxt = r_stable_cnt + 1'b1;
                    end
                    if (bus.pid_in != '0) begin
                        w_dir_nxt = ~bus.pid_in[SERVO_W-1];
                    end
                    w_lost_nxt = (bus.sensors == '0) ? r_lost_cnt + 1'b1 : '0;
                    w_fin_nxt  = (bus.sensors == '1) ? r_fin_cnt + 1'b1  : '0;
                    if (w_lost_nxt == c_lost_lim) begin
                        w_state_nxt = ST_SEARCH;
                    end else if (w_fin_nxt == c_fin_lim) begin
                        w_state_nxt = ST_FINISH;
                    end
                end
            end
            ST_SEARCH: begin
`ifdef FOLLOWER_SEARCH_TIMEOUT_EN
                w_search_nxt = r_search_cnt;
`endif
                if (w_tick) begin
                    if (bus.sensors != '0) begin
                        w_state_nxt  = ST_FOLLOW;
                        w_lost_nxt   = '0;
                        w_fin_nxt    = '0;
                        w_stable_nxt = '0;
                    end
`ifdef FOLLOWER_SEARCH_TIMEOUT_EN
                    else begin
                        w_search_nxt = r_search_cnt + 1'b1;
                        if (w_search_nxt == c_search_lim) begin
                            w_state_nxt = ST_IDLE;
                        end
                    end
`endif
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // Outputs follow the next state so they change on the same edge as the state.
        w_servo_nxt   = '0;
        w_pid_clr_nxt = 1'b1;
        w_kp_nxt      = 1'b0;
        w_ki_nxt      = 1'b0;
        w_kd_nxt      = 1'b0;
        case (w_state_nxt)
            ST_FOLLOW: begin
                w_servo_nxt   = servo_clamp(bus.pid_in, SERVO_LIM);
                w_pid_clr_nxt = 1'b0;
                w_kp_nxt      = 1'b1;
                w_kd_nxt      = 1'b1;
                w_ki_nxt      = (w_stable_nxt >= c_stable_lim);
            end
            ST_SEARCH: begin
                w_servo_nxt = w_dir_nxt ? SEARCH_MAG : -SEARCH_MAG;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_lost_cnt   <= '0;
            r_fin_cnt    <= '0;
            r_stable_cnt <= '0;
            r_last_dir   <= 1'b0;
            r_start_q    <= 1'b0;
            r_servo      <= '0;
            r_pid_clr    <= 1'b1;
            r_kp         <= 1'b0;
            r_ki         <= 1'b0;
            r_kd         <= 1'b0;
`ifdef FOLLOWER_SEARCH_TIMEOUT_EN
            r_search_cnt <= '0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_lost_cnt   <= w_lost_nxt;
            r_fin_cnt    <= w_fin_nxt;
            r_stable_cnt <= w_stable_nxt;
            r_last_dir   <= w_dir_nxt;
            r_start_q    <= bus.start;
            r_servo      <= w_servo_nxt;
            r_pid_clr    <= w_pid_clr_nxt;
            r_kp         <= w_kp_nxt;
            r_ki         <= w_ki_nxt;
            r_kd         <= w_kd_nxt;
`ifdef FOLLOWER_SEARCH_TIMEOUT_EN
            r_search_cnt <= w_search_nxt;
`endif
        end
    end

    assign bus.sample_tick    = w_tick;
    assign bus.pid_clr        = r_pid_clr;
    assign bus.kp_sw          = r_kp;
    assign bus.ki_sw          = r_ki;
    assign bus.kd_sw          = r_kd;
    assign bus.servo_cmd      = r_servo;
    assign bus.follower_state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_follower_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_follower_ctrl
// Desc   : Directed scenarios plus random stimulus against a behavioural model.
// Rev    : 1.0
// ============================================================================
module tb_follower_ctrl;

    localparam int TD     = 4;
    localparam int LOST   = 3;
    localparam int FIN    = 2;
    localparam int STABLE = 2;
    localparam int MAG    = 600;
    localparam int LIM    = 1000;
`ifdef FOLLOWER_SEARCH_TIMEOUT_EN
    localparam int TO     = 5;
`endif
    localparam int M_IDLE = 0, M_FOLLOW = 1, M_SEARCH = 2, M_FINISH = 3;

    logic clk = 1'b0;
    logic rst;

    follower_ctrl_if bus();

    follower_ctrl #(
        .TICK_DIV     (TD),
        .LOST_TICKS   (LOST),
        .FINISH_TICKS (FIN),
        .STABLE_TICKS (STABLE),
        .SEARCH_MAG   (13'sd600),
        .SERVO_LIM    (13'sd1000)
`ifdef FOLLOWER_SEARCH_TIMEOUT_EN
        ,
        .SEARCH_TIMEOUT (TO)
`endif
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: cycle phase, mode and run lengths as plain integers.
    int m_phase, m_state, m_lost, m_fin, m_stable, m_search, m_pid;
    bit m_dir, m_start_q;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic enter_follow();
        m_state  = M_FOLLOW;
        m_lost   = 0;
        m_fin    = 0;
        m_stable = 0;
    endtask

    task automatic model_edge();
        bit tick;
        bit rise;
        if (rst) begin
            m_phase = 0; m_state = M_IDLE; m_lost = 0; m_fin = 0;
            m_stable = 0; m_search = 0; m_pid = 0; m_dir = 0; m_start_q = 0;
            return;
        end
        tick      = (m_phase == TD - 1);
        m_phase   = (m_phase + 1) % TD;
        rise      = bus.start && !m_start_q;
        m_start_q = bus.start;
        m_pid     = int'(bus.pid_in);
        case (m_state)
            M_IDLE, M_FINISH: if (rise) enter_follow();
            M_FOLLOW: if (tick) begin
                m_stable = (m_stable + 1 > STABLE) ? STABLE : m_stable + 1;
                if (m_pid != 0) m_dir = (m_pid > 0);
                m_lost = (bus.sensors == 4'h0) ? m_lost + 1 : 0;
                m_fin  = (bus.sensors == 4'hF) ? m_fin + 1 : 0;
                if (m_lost >= LOST) begin
                    m_state  = M_SEARCH;
                    m_search = 0;
                end else if (m_fin >= FIN) begin
                    m_state = M_FINISH;
                end
            end
            M_SEARCH: if (tick) begin
                if (bus.sensors != 4'h0) begin
                    enter_follow();
                end else begin
                    m_search++;
`ifdef FOLLOWER_SEARCH_TIMEOUT_EN
                    if (m_search >= TO) m_state = M_IDLE;
`endif
                end
            end
            default: m_state = M_IDLE;
        endcase
    endtask

    function automatic int exp_servo();
        if (m_state == M_FOLLOW) return (m_pid > LIM) ? LIM : (m_pid < -LIM) ? -LIM : m_pid;
        if (m_state == M_SEARCH) return m_dir ? MAG : -MAG;
        return 0;
    endfunction

    task automatic compare_outputs();
        chk("state", int'(bus.follower_state), m_state);
        chk("servo_cmd", int'(bus.servo_cmd), exp_servo());
        chk("sample_tick", int'(bus.sample_tick), (m_phase == TD - 1) ? 1 : 0);
        chk("pid_clr", int'(bus.pid_clr), (m_state != M_FOLLOW) ? 1 : 0);
        chk("gains_kp_ki_kd", int'({bus.kp_sw, bus.ki_sw, bus.kd_sw}),
            (m_state == M_FOLLOW) ? ((m_stable >= STABLE) ? 7 : 5) : 0);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_outputs();
    endtask

    // Advance until n sample strobes have been consumed by a clock edge.
    task automatic run_ticks(input int n);
        int seen;
        int guard;
        seen  = 0;
        guard = 0;
        while (seen < n && guard < 16 * TD * n) begin
            if (bus.sample_tick === 1'b1) seen++;
            step();
            guard++;
        end
        if (seen < n) chk("tick_bound", seen, n);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    initial begin
        int r;
        rst = 1'b1; bus.start = 1'b0; bus.sensors = 4'h0; bus.pid_in = '0;
        repeat (3) step();
        chk("reset_state", int'(bus.follower_state), 0);
        chk("reset_pid_clr", int'(bus.pid_clr), 1);
        rst = 1'b0;
        repeat (20) step();
        chk("idle_state", int'(bus.follower_state), 0);
        chk("idle_servo", int'(bus.servo_cmd), 0);

        bus.sensors = 4'b0110; bus.pid_in = 13'sd200;
        pulse_start();
        chk("follow_entry_state", int'(bus.follower_state), 1);
        chk("follow_entry_servo", int'(bus.servo_cmd), 200);
        chk("follow_entry_ki", int'(bus.ki_sw), 0);
        run_ticks(2);
        chk("follow_ki_on", int'(bus.ki_sw), 1);
        bus.pid_in = 13'sd1500;  step();
        chk("clamp_pos", int'(bus.servo_cmd), 1000);
        bus.pid_in = -13'sd1500; step();
        chk("clamp_neg", int'(bus.servo_cmd), -1000);

        bus.pid_in = 13'sd50; bus.sensors = 4'h0;
        run_ticks(3);
        chk("search_state", int'(bus.follower_state), 2);
        chk("search_servo", int'(bus.servo_cmd), 600);
        bus.sensors = 4'b0001;
        run_ticks(1);
        chk("refound_state", int'(bus.follower_state), 1);
        chk("refound_ki", int'(bus.ki_sw), 0);

        bus.sensors = 4'hF;
        run_ticks(2);
        chk("finish_state", int'(bus.follower_state), 3);
        chk("finish_servo", int'(bus.servo_cmd), 0);
        pulse_start();
        chk("restart_state", int'(bus.follower_state), 1);

        bus.sensors = 4'h0;    run_ticks(2);
        bus.sensors = 4'b0100; run_ticks(1);
        bus.sensors = 4'h0;    run_ticks(2);
        chk("lost_cleared_state", int'(bus.follower_state), 1);
        run_ticks(1);
        chk("lost_again_state", int'(bus.follower_state), 2);
        rst = 1'b1; step(); rst = 1'b0;
        chk("rst_in_search_state", int'(bus.follower_state), 0);
        chk("rst_in_search_servo", int'(bus.servo_cmd), 0);

        bus.sensors = 4'b0110;
        pulse_start();
        run_ticks(2);
        bus.sensors = 4'h0;
        run_ticks(3);
        chk("timeout_entry_state", int'(bus.follower_state), 2);
`ifdef FOLLOWER_SEARCH_TIMEOUT_EN
        run_ticks(5);
        chk("timeout_state", int'(bus.follower_state), 0);
`else
        run_ticks(50);
        chk("no_timeout_state", int'(bus.follower_state), 2);
`endif

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                r = int'($urandom_range(0, 9));
                bus.sensors = (r < 4) ? 4'h0 : (r < 6) ? 4'hF : 4'($urandom_range(1, 14));
            end
            if ($urandom_range(0, 5) == 0)
                bus.pid_in = ($urandom_range(0, 7) == 0) ? 13'sd0 : 13'(int'($urandom_range(0, 4000)) - 2000);
            bus.start = ($urandom_range(0, 39) == 0);
            rst       = ($urandom_range(0, 599) == 0);
            step();
        end
        rst = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/follower_ctrl.md
Name: follower_ctrl

Overview:
Mode sequencer for the line-follower steering path, sitting between the PID block and the servo PWM generator. It issues the PID sample strobe and the gain-term enables (kp_sw/ki_sw/kd_sw). It selects the servo command: PID output, a search sweep, or neutral. It detects line-lost and finish-line conditions from the 4-bit sensor bar.

Parameters:
TICK_DIV, 100000, clk cycles per control sample tick (1 kHz at 100 MHz)
LOST_TICKS, 20, consecutive ticks with sensors==4'b0000 before entering SEARCH
FINISH_TICKS, 10, consecutive ticks with sensors==4'b1111 before entering FINISH
STABLE_TICKS, 50, FOLLOW ticks before the integral term is enabled
SEARCH_MAG, 13'sd600, magnitude of the search steering command
SERVO_LIM, 13'sd1000, symmetric clamp on servo_cmd
SEARCH_TIMEOUT, 2000, ticks allowed in SEARCH (optional feature only)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  start button, already debounced, level
sensors  in  4  line sensor bar, 1 = line seen
pid_in  in  13 signed  PID controller output
sample_tick  out  1  one-cycle PID sample strobe
pid_clr  out  1  clears PID integrator/derivative history
kp_sw  out  1  proportional term enable
ki_sw  out  1  integral term enable
kd_sw  out  1  derivative term enable
servo_cmd  out  13 signed  command to the servo PWM block
follower_state  out  2  current state encoding

Behaviour:
- Reset (synchronous, active-high, clocked by clk): state=IDLE, tick counter=0, all run counters=0, last_dir=0, start_q=0. Reset outputs: servo_cmd=0, sample_tick=0, pid_clr=1, kp_sw=ki_sw=kd_sw=0, follower_state=2'd0. Reset asserted mid-run aborts immediately on the next edge.
- Tick: counter counts 0..TICK_DIV-1 and wraps. sample_tick=1 for exactly one cycle when the counter equals TICK_DIV-1. The tick runs in every state.
- start_rise = start & ~start_q, evaluated every clk. All other transitions are evaluated only on sample_tick cycles.
- States: IDLE=0, FOLLOW=1, SEARCH=2, FINISH=3.
- IDLE: servo_cmd=0, pid_clr=1, gains off. start_rise -> FOLLOW, with stable_cnt=0.
- FOLLOW: servo_cmd=clamp(pid_in, ±SERVO_LIM), pid_clr=0, kp_sw=kd_sw=1. ki_sw=1 once stable_cnt>=STABLE_TICKS; stable_cnt saturates.
  - On a tick with pid_in!=0: last_dir<=(pid_in>0).
  - lost_cnt increments on ticks with sensors==0 and clears otherwise.
  - fin_cnt increments on ticks with sensors==4'hF and clears otherwise.
  - lost_cnt reaching LOST_TICKS -> SEARCH.
  - fin_cnt reaching FINISH_TICKS -> FINISH.
  - Both counters cannot reach their limits on the same tick (mutually exclusive patterns).
- SEARCH: servo_cmd = last_dir ? +SEARCH_MAG : -SEARCH_MAG. pid_clr=1, gains off. A tick with sensors!=0 -> FOLLOW, with stable_cnt=0 and lost_cnt=0.
- FINISH: servo_cmd=0, pid_clr=1, gains off. start_rise -> FOLLOW.
- start_rise in FOLLOW or SEARCH is ignored.
- All outputs are registered. The state change becomes visible one cycle after the deciding tick.
- Clamp: values >SERVO_LIM output SERVO_LIM; values <-SERVO_LIM output -SERVO_LIM.

Optional Feature:
FOLLOWER_SEARCH_TIMEOUT_EN:
- Defined: search_cnt increments per tick in SEARCH. On reaching SEARCH_TIMEOUT -> IDLE (vehicle stops). search_cnt clears on SEARCH entry.
- Undefined: SEARCH persists until the line is found; no search_cnt logic is synthesized.

Decomposition:
- Package follower_pkg: state typedef (IDLE/FOLLOW/SEARCH/FINISH), SERVO_W=13, SENSOR_W=4, shared with the PID and PWM blocks.
- One sub-module, ctrl_tick_gen (parameter TICK_DIV, outputs sample_tick).

Test Plan:
- Use TICK_DIV=4, LOST_TICKS=3, FINISH_TICKS=2, STABLE_TICKS=2, SEARCH_TIMEOUT=5 for all scenarios.
- Reset, then idle 20 cycles -> servo_cmd=0, pid_clr=1, sample_tick pulses every 4th cycle, state=0.
- start pulse, sensors=4'b0110, pid_in=+200 -> state=1 next cycle, servo_cmd=200, kp/kd=1, ki=1 after 2 ticks; pid_in=+1500 -> servo_cmd=1000, pid_in=-1500 -> -1000.
- In FOLLOW with pid_in=+50, then sensors=0 for 3 ticks -> state=2, servo_cmd=+600. sensors=4'b0001 at the next tick -> state=1, ki_sw=0 again.
- sensors=4'hF for 2 ticks in FOLLOW -> state=3, servo_cmd=0. start pulse -> state=1.
- sensors=0 for 2 ticks then 4'b0100 -> lost_cnt cleared, no SEARCH entry. Assert rst in SEARCH -> IDLE outputs next cycle.
- With FOLLOWER_SEARCH_TIMEOUT_EN: remain lost 5 ticks in SEARCH -> state=0. Without the macro: state stays 2 after 50 ticks.
